tag_wb_buffer: RTL and testbench

TAG_WB_BUFFER -- requirements
Module: tag_wb_buffer

---
 rtl/tag_wb_buffer.sv | 113 +++++++++++
 tb/tb_tag_wb_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_wb_buffer.sv
// Write-back buffer: FIFO of evicted dirty lines with coalescing and a refill lookup port.
// Latency: an eviction is presented to memory the cycle after acceptance; the lookup result is registered (1 cycle).
// Backpressure: wb_ready drops only when full; mem_ready low holds the head stable.
module tag_wb_buffer #(
    parameter int AW    = 32,
    parameter int DW    = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DW-1:0]            wb_data,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_data,
    input  logic                     lk_valid,
    input  logic [AW-1:0]            lk_addr,
    output logic                     lk_rsp,
    output logic                     lk_hit,
    output logic [DW-1:0]            lk_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail;

    logic          wb_acc, alloc, retire;
    logic          co_hit;
    logic [PW-1:0] co_idx, co_scan, wr_idx, lk_scan;
    logic          lk_hit_c;
    logic [DW-1:0] lk_data_c;

    always_comb begin
        wb_ready  = (count != FULL);
        mem_valid = (count != '0);
        mem_addr  = addr_q[head];
        mem_data  = data_q[head];
        wb_acc    = wb_valid && wb_ready;
        retire    = mem_valid && mem_ready;
        alloc     = wb_acc && !co_hit;
        wr_idx    = co_hit ? co_idx : tail;
    end

    // The head is excluded: it may already be on the memory bus and must not change.
    always_comb begin
        co_hit  = 1'b0;
        co_idx  = head;
        co_scan = head;
        for (int i = 1; i < DEPTH; i++) begin
            co_scan = head + PW'(i);
            if (CW'(i) < count && addr_q[co_scan] == wb_addr) begin
                co_hit = 1'b1;
                co_idx = co_scan;
            end
        end
    end

    // Scan oldest to youngest so younger matches win; the same-cycle eviction wins over all.
    always_comb begin
        lk_hit_c  = 1'b0;
        lk_data_c = '0;
        lk_scan   = head;
        for (int i = 0; i < DEPTH; i++) begin
            lk_scan = head + PW'(i);
            if (CW'(i) < count && addr_q[lk_scan] == lk_addr) begin
                lk_hit_c  = 1'b1;
                lk_data_c = data_q[lk_scan];
            end
        end
        if (wb_acc && wb_addr == lk_addr) begin
            lk_hit_c  = 1'b1;
            lk_data_c = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            lk_rsp  <= 1'b0;
            lk_hit  <= 1'b0;
            lk_data <= '0;
        end else begin
            if (alloc) tail <= tail + 1'b1;
            if (retire) head <= head + 1'b1;
            case ({alloc, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            lk_rsp  <= lk_valid;
            lk_hit  <= lk_valid && lk_hit_c;
            lk_data <= (lk_valid && lk_hit_c) ? lk_data_c : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wb_acc) begin
            addr_q[wr_idx] <= wb_addr;
            data_q[wr_idx] <= wb_data;
        end
    end

endmodule

// File: tb/tb_tag_wb_buffer.sv
// Directed self-checking bench for tag_wb_buffer with hand-computed expectations.
module tb_tag_wb_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    logic         mem_valid;
    logic         mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data;
    logic         lk_valid;
    logic [31:0]  lk_addr;
    logic         lk_rsp;
    logic         lk_hit;
    logic [127:0] lk_data;
    logic [2:0]   count;

    int checks = 0;
    int errors = 0;

    logic [127:0] d1 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    logic [127:0] d2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    logic [127:0] d3 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    logic [127:0] d5 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    logic [127:0] dx = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;

    tag_wb_buffer #(.AW(32), .DW(128), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_rsp(lk_rsp), .lk_hit(lk_hit),
        .lk_data(lk_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic evict(input logic [31:0] a, input logic [127:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        step();
        wb_valid = 1'b0;
    endtask

    function automatic logic [127:0] pat(input int i);
        return {32'hA0A0_0000 + 32'(i), 96'h0};
    endfunction

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        mem_ready = 1'b0; lk_valid = 1'b0; lk_addr = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_mem_valid", 128'(mem_valid), 128'd0);
        chk("rst_wb_ready", 128'(wb_ready), 128'd1);
        chk("rst_lk_rsp", 128'(lk_rsp), 128'd0);
        chk("rst_lk_hit", 128'(lk_hit), 128'd0);
        chk("rst_lk_data", lk_data, 128'd0);

        // Lookup bypass of a same-cycle eviction into an empty buffer
        lk_valid = 1'b1; lk_addr = 32'h40;
        evict(32'h40, d5);
        lk_addr = 32'h41;
        chk("byp_lk_rsp", 128'(lk_rsp), 128'd1);
        chk("byp_lk_hit", 128'(lk_hit), 128'd1);
        chk("byp_lk_data", lk_data, d5);
        chk("byp_mem_valid", 128'(mem_valid), 128'd1);
        chk("byp_mem_addr", 128'(mem_addr), 128'h40);
        step();
        lk_valid = 1'b0;
        chk("miss_lk_rsp", 128'(lk_rsp), 128'd1);
        chk("miss_lk_hit", 128'(lk_hit), 128'd0);
        chk("miss_lk_data", lk_data, 128'd0);
        step();
        chk("idle_lk_rsp", 128'(lk_rsp), 128'd0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("byp_drained", 128'(count), 128'd0);

        // Fill to full, then drain in order; lookup the head as it retires
        for (int i = 0; i < 4; i++) evict(32'h10 + 32'(i), pat(i));
        chk("full_count", 128'(count), 128'd4);
        chk("full_wb_ready", 128'(wb_ready), 128'd0);
        mem_ready = 1'b1;
        lk_valid = 1'b1; lk_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 128'(mem_valid), 128'd1);
            chk("drain_addr", 128'(mem_addr), 128'h10 + 128'(i));
            chk("drain_data", mem_data, pat(i));
            step();
            if (i == 0) begin
                lk_valid = 1'b0;
                chk("retire_lk_hit", 128'(lk_hit), 128'd1);
                chk("retire_lk_data", lk_data, pat(0));
            end
        end
        mem_ready = 1'b0;
        chk("drain_empty", 128'(count), 128'd0);
        chk("drain_mem_valid", 128'(mem_valid), 128'd0);

        // Coalesce into a non-head entry
        evict(32'h20, d1);
        evict(32'h21, dx);
        evict(32'h21, d2);
        chk("coal_count", 128'(count), 128'd2);
        mem_ready = 1'b1;
        chk("coal_addr0", 128'(mem_addr), 128'h20);
        chk("coal_data0", mem_data, d1);
        step();
        chk("coal_addr1", 128'(mem_addr), 128'h21);
        chk("coal_data1", mem_data, d2);
        step();
        chk("coal_once", 128'(count), 128'd0);
        mem_ready = 1'b0;

        // Head match allocates a new entry; lookup prefers the youngest
        evict(32'h30, d1);
        evict(32'h30, d2);
        chk("head_count", 128'(count), 128'd2);
        lk_valid = 1'b1; lk_addr = 32'h30;
        step();
        lk_valid = 1'b0;
        chk("young_lk_hit", 128'(lk_hit), 128'd1);
        chk("young_lk_data", lk_data, d2);
        mem_ready = 1'b1;
        chk("head_data0", mem_data, d1);
        step();
        chk("head_data1", mem_data, d2);
        step();
        mem_ready = 1'b0;
        chk("head_empty", 128'(count), 128'd0);

        // Coalescing accept together with a retire nets count-1
        evict(32'h70, d1);
        evict(32'h71, d2);
        mem_ready = 1'b1;
        evict(32'h71, d3);
        chk("coal_ret_count", 128'(count), 128'd1);
        chk("coal_ret_data", mem_data, d3);
        step();
        mem_ready = 1'b0;
        chk("coal_ret_empty", 128'(count), 128'd0);

        // Full buffer: stalled eviction leaves state untouched, then retire frees a slot
        for (int i = 0; i < 4; i++) evict(32'h50 + 32'(i), pat(8 + i));
        wb_valid = 1'b1; wb_addr = 32'h52; wb_data = dx;
        step();
        chk("bp_count", 128'(count), 128'd4);
        wb_addr = 32'h54; wb_data = d3; mem_ready = 1'b1;
        chk("bp_wb_ready", 128'(wb_ready), 128'd0);
        chk("bp_head", 128'(mem_addr), 128'h50);
        step();
        mem_ready = 1'b0;
        chk("ret_count", 128'(count), 128'd3);
        chk("ret_wb_ready", 128'(wb_ready), 128'd1);
        step();
        wb_valid = 1'b0;
        chk("refill_count", 128'(count), 128'd4);
        mem_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("bp_drain_addr", 128'(mem_addr), 128'h50 + 128'(i));
            chk("bp_drain_data", mem_data, (i == 4) ? d3 : pat(8 + i));
            step();
        end
        mem_ready = 1'b0;

        // Mid-operation reset discards pending writes
        for (int i = 0; i < 3; i++) evict(32'h60 + 32'(i), pat(16 + i));
        chk("pre_rst_count", 128'(count), 128'd3);
        chk("pre_rst_mem_valid", 128'(mem_valid), 128'd1);
        rst = 1'b1; mem_ready = 1'b1;
        step();
        rst = 1'b0; mem_ready = 1'b0;
        chk("mid_rst_count", 128'(count), 128'd0);
        chk("mid_rst_mem_valid", 128'(mem_valid), 128'd0);
        chk("mid_rst_wb_ready", 128'(wb_ready), 128'd1);
        lk_valid = 1'b1; lk_addr = 32'h60;
        step();
        lk_valid = 1'b0;
        chk("post_rst_lk_rsp", 128'(lk_rsp), 128'd1);
        chk("post_rst_lk_hit", 128'(lk_hit), 128'd0);
        chk("post_rst_lk_data", lk_data, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
